// File: rtl/memory_pkg.sv
// Shared types for the eight-word register file: address type, FSM states
// and word count.
package memory_pkg;
    localparam int N_WORDS = 8;

    typedef logic [2:0] addr8_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;
endpackage

// File: rtl/ram8_port_if.sv
// Request/response bus of ram8_port. Handshake: a transfer happens on a rising
// edge where valid and ready are both high; valid never waits on ready.
interface ram8_port_if #(
    parameter int WIDTH = 16
);
    import memory_pkg::*;

    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_we_i;
    addr8_t           req_addr_i;
    logic [WIDTH-1:0] req_data_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_data_o;
    logic             rsp_uninit_o;
    logic [7:0]       written_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_uninit_o, written_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_uninit_o, written_o
    );
endinterface

// File: rtl/ram8_port_dmux8way.sv
// 8-way demultiplexer: routes in_i to the output selected by sel_i, all other
// outputs are zero.
module dmux8way #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]      in_i,
    input  logic [2:0]            sel_i,
    output logic [7:0][WIDTH-1:0] out_o
);
    always_comb begin
        out_o        = '0;
        out_o[sel_i] = in_i;
    end
endmodule

// File: rtl/ram8_port.sv
// Eight-word register file behind a valid/ready request port with a
// registered, backpressurable response.
module ram8_port
    import memory_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    ram8_port_if.slave  bus,
    output state_e      state_o
);
    state_e              state_q, state_d;
    logic [WIDTH-1:0]    mem_q [N_WORDS];
    logic [N_WORDS-1:0]  written_q;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                rsp_uninit_q, rsp_uninit_d;
    logic                rsp_valid;
    logic                acc;
    logic [WIDTH-1:0]    rd_word;
    logic [7:0][0:0]     load;

    assign rsp_valid       = (state_q == RESP);
    assign bus.req_ready_o = ~rsp_valid | bus.rsp_ready_i;
    assign acc             = bus.req_valid_i & bus.req_ready_o;

    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_data_o   = rsp_data_q;
    assign bus.rsp_uninit_o = rsp_uninit_q;
    assign bus.written_o    = written_q;
    assign state_o          = state_q;

    dmux8way #(.WIDTH(1)) u_load_dmux (
        .in_i  (acc & bus.req_we_i),
        .sel_i (bus.req_addr_i),
        .out_o (load)
    );

    always_comb begin
        rd_word = RESET_VAL;
        case (bus.req_addr_i)
            3'd0: rd_word = mem_q[0];
            3'd1: rd_word = mem_q[1];
            3'd2: rd_word = mem_q[2];
            3'd3: rd_word = mem_q[3];
            3'd4: rd_word = mem_q[4];
            3'd5: rd_word = mem_q[5];
            3'd6: rd_word = mem_q[6];
            3'd7: rd_word = mem_q[7];
            default: rd_word = RESET_VAL;
        endcase
    end

    // A response is loaded on every accept; otherwise it is held unchanged.
    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_uninit_d = rsp_uninit_q;
        case (state_q)
            IDLE: if (acc) state_d = RESP;
            RESP: if (bus.rsp_ready_i && !acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (acc) begin
            rsp_data_d   = bus.req_we_i ? bus.req_data_i : rd_word;
            rsp_uninit_d = bus.req_we_i ? 1'b0 : ~written_q[bus.req_addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rsp_data_q   <= '0;
            rsp_uninit_q <= 1'b0;
            written_q    <= '0;
            for (int n = 0; n < N_WORDS; n++) mem_q[n] <= RESET_VAL;
        end else begin
            state_q      <= state_d;
            rsp_data_q   <= rsp_data_d;
            rsp_uninit_q <= rsp_uninit_d;
            for (int n = 0; n < N_WORDS; n++) begin
                if (load[n][0]) begin
                    mem_q[n]     <= bus.req_data_i;
                    written_q[n] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram8_port.sv
// Directed and randomised bench for ram8_port with an in-order response
// scoreboard driven by a reference model.
module tb_ram8_port;
    import memory_pkg::*;

    logic   clk_i;
    logic   rst_ni;
    state_e state;
    int     checks;
    int     failures;
    int     stalls;
    logic   bp_en;

    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    logic [15:0] mdl_mem [8];
    logic [7:0]  mdl_wr;
    logic        hold_prev;
    logic [16:0] hold_val;
    logic [16:0] mon_cur;

    ram8_port_if #(.WIDTH(16)) bus ();

    ram8_port #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .bus     (bus),
        .state_o (state)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        got_q.delete();
        for (int n = 0; n < 8; n++) mdl_mem[n] = 16'h0000;
        mdl_wr    = 8'h00;
        hold_prev = 1'b0;
    endtask

    // Inputs change only at posedge+1; outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic [2:0] addr, input logic [15:0] data);
        int wait_cyc;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_data_i  = data;
        wait_cyc = 0;
        @(negedge clk_i);
        while (!bus.req_ready_o) begin
            stalls++;
            wait_cyc++;
            if (wait_cyc > 200) begin
                check("req_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk_i);
        end
        tick();
    endtask

    task automatic idle();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    task automatic expect_got(input string tag, input logic [16:0] exp);
        if (got_q.size() == 0) check({tag, "_missing"}, 32'd1, 32'd0);
        else check(tag, got_q.pop_front(), exp);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            mon_cur = {bus.rsp_uninit_o, bus.rsp_data_o};
            if (hold_prev && bus.rsp_valid_o) check("rsp_stable", mon_cur, hold_val);
            hold_prev = bus.rsp_valid_o && !bus.rsp_ready_i;
            hold_val  = mon_cur;
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                got_q.push_back(mon_cur);
                if (exp_q.size() == 0) check("rsp_extra", 32'd1, 32'd0);
                else check("rsp_sb", mon_cur, exp_q.pop_front());
            end
            if (bus.req_valid_i && bus.req_ready_o) begin
                if (bus.req_we_i) begin
                    exp_q.push_back({1'b0, bus.req_data_i});
                    mdl_mem[bus.req_addr_i] = bus.req_data_i;
                    mdl_wr[bus.req_addr_i]  = 1'b1;
                end else begin
                    exp_q.push_back({~mdl_wr[bus.req_addr_i], mdl_mem[bus.req_addr_i]});
                end
            end
        end
    end

    always @(posedge clk_i) begin
        if (bp_en) begin
            #1;
            bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        stalls   = 0;
        bp_en    = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 3'd0;
        bus.req_data_i  = 16'h0000;
        bus.rsp_ready_i = 1'b1;
        model_clear();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Reset state, then read every word
        @(negedge clk_i);
        check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check("rst_rsp_data", bus.rsp_data_o, 16'h0000);
        check("rst_rsp_uninit", bus.rsp_uninit_o, 1'b0);
        check("rst_written", bus.written_o, 8'h00);
        check("rst_ready", bus.req_ready_o, 1'b1);
        check("rst_state", state, IDLE);
        tick();
        for (int n = 0; n < 8; n++) req(1'b0, 3'(n), 16'h0000);
        idle();
        drain();
        check("rd_init_count", got_q.size(), 8);
        for (int n = 0; n < 8; n++) expect_got("rd_init", {1'b1, 16'h0000});
        check("rd_init_written", bus.written_o, 8'h00);

        // Write then read same address
        got_q.delete();
        req(1'b1, 3'd3, 16'hA5A5);
        req(1'b0, 3'd3, 16'h0000);
        idle();
        drain();
        expect_got("wr3_echo", {1'b0, 16'hA5A5});
        expect_got("rd3", {1'b0, 16'hA5A5});
        check("wr3_written", bus.written_o, 8'h08);

        // Back-to-back fill and reverse readback
        got_q.delete();
        stalls = 0;
        for (int n = 0; n < 8; n++) req(1'b1, 3'(n), 16'h1000 + 16'(n));
        for (int n = 7; n >= 0; n--) req(1'b0, 3'(n), 16'h0000);
        idle();
        drain();
        check("b2b_no_stall", stalls, 0);
        for (int n = 0; n < 8; n++) expect_got("b2b_wr_echo", {1'b0, 16'h1000 + 16'(n)});
        for (int n = 7; n >= 0; n--) expect_got("b2b_rd", {1'b0, 16'h1000 + 16'(n)});
        check("b2b_written", bus.written_o, 8'hFF);

        // Backpressure: held read response, pending write to addr 2
        got_q.delete();
        bus.rsp_ready_i = 1'b0;
        req(1'b0, 3'd5, 16'h0000);
        bus.req_we_i   = 1'b1;
        bus.req_addr_i = 3'd2;
        bus.req_data_i = 16'hBEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check("bp_rsp_valid", bus.rsp_valid_o, 1'b1);
            check("bp_rsp_data", bus.rsp_data_o, 16'h1005);
            check("bp_ready", bus.req_ready_o, 1'b0);
            tick();
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_ready", bus.req_ready_o, 1'b1);
        tick();
        req(1'b0, 3'd2, 16'h0000);
        idle();
        drain();
        expect_got("bp_rd5", {1'b0, 16'h1005});
        expect_got("bp_wr2_echo", {1'b0, 16'hBEEF});
        expect_got("bp_rd2", {1'b0, 16'hBEEF});

        // Asynchronous reset while a response is held
        got_q.delete();
        bus.rsp_ready_i = 1'b0;
        req(1'b1, 3'd6, 16'hFFFF);
        idle();
        @(negedge clk_i);
        check("arst_pre_valid", bus.rsp_valid_o, 1'b1);
        check("arst_pre_data", bus.rsp_data_o, 16'hFFFF);
        #2;
        rst_ni = 1'b0;
        model_clear();
        #1;
        check("arst_valid", bus.rsp_valid_o, 1'b0);
        check("arst_written", bus.written_o, 8'h00);
        check("arst_state", state, IDLE);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b1;
        req(1'b0, 3'd6, 16'h0000);
        idle();
        drain();
        expect_got("arst_rd6", {1'b1, 16'h0000});

        // Random traffic with random response backpressure
        got_q.delete();
        bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                idle();
                tick();
            end
        end
        idle();
        bp_en = 1'b0;
        tick();
        bus.rsp_ready_i = 1'b1;
        drain();
        check("rand_drained", exp_q.size(), 0);
        check("rand_rsp_count", got_q.size(), 1000);
        check("rand_idle", bus.rsp_valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram8_port.md
Name: ram8_port

Overview:
- Eight-word register file with a single valid/ready request port and a registered response port.
- Sits directly downstream of the 8-way write-enable demultiplexer. It consumes the one-hot load strobes produced by that stage and owns the storage words, the read mux and the request/response handshake.
- Building block for RAM64 and larger banks. Also serves as a standalone scratch memory for the CPU test harness.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).
- RESET_VAL, '0, value loaded into every word on reset.

Ports:
- clk_i  input  1  single clock, all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block accepts a request this cycle.
- req_we_i  input  1  1 = write, 0 = read.
- req_addr_i  input  3  word address 0..7.
- req_data_i  input  WIDTH  write data; ignored on reads.
- rsp_valid_o  output  1  response held.
- rsp_ready_i  input  1  consumer takes the response.
- rsp_data_o  output  WIDTH  read data, or echoed write data.
- rsp_uninit_o  output  1  read targeted a word never written since reset.
- written_o  output  8  per-word "written since reset" flags, bit n = word n.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - all 8 words = RESET_VAL
  - rsp_valid_o = 0
  - rsp_data_o = '0
  - rsp_uninit_o = 0
  - written_o = 8'h00
  - FSM = IDLE
  - Takes effect immediately, including mid-transaction. Any pending response is discarded. Release is synchronous to clk_i.
- Accept condition: acc = req_valid_i & req_ready_o.
- req_ready_o = ~rsp_valid_o | rsp_ready_i. This is combinational and gives back-to-back throughput of 1 transaction per cycle.
- FSM states:
  - IDLE (no response held): acc -> RESP; else stay in IDLE.
  - RESP (response held, rsp_valid_o = 1):
    - rsp_ready_i & acc -> RESP, loaded with the new response.
    - rsp_ready_i & ~acc -> IDLE.
    - ~rsp_ready_i -> RESP, with the response held stable.
- Write (acc & req_we_i):
  - Load strobes come from the demux stage: value = acc & req_we_i, sel = req_addr_i.
  - word[addr] <= req_data_i at the accept edge.
  - written_o[addr] <= 1.
  - Response on the next cycle: rsp_data_o = req_data_i, rsp_uninit_o = 0.
- Read (acc & ~req_we_i):
  - Response on the next cycle: rsp_data_o = word[addr] as stored before the accept edge.
  - rsp_uninit_o = ~written_o[addr].
  - Latency is 1 cycle from accept to rsp_valid_o.
- Back-to-back write A then read A: the read is accepted one cycle later and returns the new data. Storage is already updated, so no bypass is required.
- Only one request is accepted per cycle, so simultaneous read and write is impossible. Holding req_valid_i while req_ready_o = 0 has no effect; the request stays pending.
- Response stability: while rsp_valid_o & ~rsp_ready_i, rsp_data_o and rsp_uninit_o must not change.
- Address is 3 bits, so every value 0..7 is legal. There is no out-of-range case.
- written_o flags are sticky until reset.

Decomposition:
- Shared package (memory_pkg):
  - typedef addr8_t (logic [2:0])
  - state enum {IDLE, RESP}
  - constant N_WORDS = 8
- Sub-module: instantiate the team's existing 8-way demultiplexer with WIDTH=1 for the load-strobe decode.
- The read mux is inline case logic; no further sub-modules.

Test Plan:
- Reset then read all 8 addresses with rsp_ready_i = 1 -> each response is 16'h0000 with rsp_uninit_o = 1; written_o = 8'h00.
- Write 16'hA5A5 to addr 3, then read addr 3 on the next cycle -> write response 16'hA5A5; read response 16'hA5A5 with rsp_uninit_o = 0; written_o = 8'h08.
- Write word n = 16'h1000+n for n = 0..7 back-to-back, then read 7..0 back-to-back -> req_ready_o stays 1 throughout; reads return 16'h1007..16'h1000 in order; written_o = 8'hFF.
- Read addr 5 with rsp_ready_i = 0 for 4 cycles while req_valid_i is held with a write to addr 2 -> rsp_valid_o = 1 and rsp_data_o are stable; req_ready_o = 0; word 2 is unchanged until rsp_ready_i rises, then the write is accepted that same cycle.
- Assert rst_ni low asynchronously (between edges) while a response is held after writing 16'hFFFF to addr 6 -> rsp_valid_o drops immediately; after release, a read of addr 6 returns RESET_VAL with rsp_uninit_o = 1.
- Random mix of 1000 reads/writes with random rsp_ready_i backpressure -> responses match a scoreboard model in order; no response is dropped or duplicated.
